// File: rtl/mul_div_pkg.sv
// ============================================================================
// Module      : mul_div_pkg
// Description : Shared types for the multi-cycle multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mul_div_pkg;

  // Control FSM states, common to the multiplier and the divider
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ITER  = 2'd1,
    ST_FIXUP = 2'd2,
    ST_DONE  = 2'd3
  } md_state_e;

  localparam logic DIV_UNSIGNED = 1'b0;
  localparam logic DIV_SIGNED   = 1'b1;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } MUL_DIV_OP;

  function automatic logic op_is_signed_div(input MUL_DIV_OP op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

`default_nettype wire

// File: rtl/div_sign_fixup.sv
// ============================================================================
// Module      : div_sign_fixup
// Description : Conditional two's-complement negation (magnitude / sign fixup).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_sign_fixup #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value_in,
  input  logic             negate,
  output logic [WIDTH-1:0] value_out
);

  // The most-negative value maps onto itself, which reads correctly as an
  // unsigned magnitude.
  assign value_out = negate ? (~value_in + WIDTH'(1)) : value_in;

endmodule

`default_nettype wire

// File: rtl/shift_sub_divider.sv
// ============================================================================
// Module      : shift_sub_divider
// Description : Iterative restoring divider, one quotient bit per cycle,
//               signed/unsigned, RISC-V special results.
//               Optional macro DIV_FAST_PATH_EN: divide-by-zero and signed
//               overflow complete in one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_sub_divider
  import mul_div_pkg::*;
#(
  parameter int OPERAND_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     div_signed,
  input  logic [OPERAND_WIDTH-1:0] dividend,
  input  logic [OPERAND_WIDTH-1:0] divisor,
  output logic [OPERAND_WIDTH-1:0] quotient,
  output logic [OPERAND_WIDTH-1:0] remainder,
  output logic                     done
);

  localparam int W     = OPERAND_WIDTH;
  localparam int CNT_W = $clog2(OPERAND_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OPERAND_WIDTH - 1);

  md_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W:0]     rem_q, rem_d;
  logic [W-1:0]   dvd_q, dvd_d;
  logic [W-1:0]   dvs_q, dvs_d;
  logic           neg_quo_q, neg_quo_d;
  logic           neg_rem_q, neg_rem_d;
  logic [W-1:0]   quo_res_q, quo_res_d;
  logic [W-1:0]   rem_res_q, rem_res_d;

  logic [W-1:0]   fix_a_in, fix_a_out;
  logic [W-1:0]   fix_b_in, fix_b_out;
  logic           fix_a_neg, fix_b_neg;
  logic [W:0]     shifted;
  logic [W:0]     trial;
  logic           divisor_zero;

  // Two negators time-shared: operand magnitudes in IDLE, result signs in FIXUP
  always_comb begin
    fix_a_in  = dividend;
    fix_a_neg = div_signed & dividend[W-1];
    fix_b_in  = divisor;
    fix_b_neg = div_signed & divisor[W-1];
    if (state_q == ST_FIXUP) begin
      fix_a_in  = dvd_q;
      fix_a_neg = neg_quo_q;
      fix_b_in  = rem_q[W-1:0];
      fix_b_neg = neg_rem_q;
    end
  end

  div_sign_fixup #(.WIDTH(W)) u_fix_a (
    .value_in  (fix_a_in),
    .negate    (fix_a_neg),
    .value_out (fix_a_out)
  );

  div_sign_fixup #(.WIDTH(W)) u_fix_b (
    .value_in  (fix_b_in),
    .negate    (fix_b_neg),
    .value_out (fix_b_out)
  );

  assign divisor_zero = (divisor == '0);
  assign shifted      = {rem_q[W-1:0], dvd_q[W-1]};
  assign trial        = shifted - {1'b0, dvs_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    quo_res_d = quo_res_q;
    rem_res_d = rem_res_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dvd_d     = fix_a_out;
          dvs_d     = fix_b_out;
          neg_quo_d = div_signed & (dividend[W-1] ^ divisor[W-1]) & ~divisor_zero;
          neg_rem_d = div_signed & dividend[W-1];
          rem_d     = '0;
          cnt_d     = '0;
          state_d   = ST_ITER;
`ifdef DIV_FAST_PATH_EN
          if (divisor_zero) begin
            quo_res_d = '1;
            rem_res_d = dividend;
            state_d   = ST_DONE;
          end else if ((div_signed == DIV_SIGNED) && (dividend == {1'b1, {(W-1){1'b0}}})
                       && (divisor == '1)) begin
            quo_res_d = {1'b1, {(W-1){1'b0}}};
            rem_res_d = '0;
            state_d   = ST_DONE;
          end
`endif
        end
      end
      ST_ITER: begin
        // Negative trial means the divisor did not fit: keep the shifted remainder
        if (trial[W]) begin
          rem_d = shifted;
          dvd_d = {dvd_q[W-2:0], 1'b0};
        end else begin
          rem_d = trial;
          dvd_d = {dvd_q[W-2:0], 1'b1};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_FIXUP;
        end
      end
      ST_FIXUP: begin
        quo_res_d = fix_a_out;
        rem_res_d = fix_b_out;
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        if (!start) begin
          quo_res_d = '0;
          rem_res_d = '0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      quo_res_q <= '0;
      rem_res_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      quo_res_q <= quo_res_d;
      rem_res_q <= rem_res_d;
    end
  end

  assign done      = (state_q == ST_DONE);
  assign quotient  = done ? quo_res_q : '0;
  assign remainder = done ? rem_res_q : '0;

endmodule

`default_nettype wire
